// File: rtl/hc595_frame_receiver.sv
// Receive-side model of a 74HC595 serial link: samples ds/shcp/stcp/oe and rebuilds {seg, selection} frames.
// Optional hex decode of the latched segment byte is enabled with the SEG_DECODE_EN macro.
module hc595_frame_receiver #(
   parameter int FRAME_BITS     = 14,
   parameter int SYNC_STAGES    = 2,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input  logic       system_clock,
   input  logic       system_reset,
   input  logic       ds,
   input  logic       shcp,
   input  logic       stcp,
   input  logic       oe,
   output logic [7:0] seg,
   output logic [5:0] selection,
   output logic       frame_valid,
   output logic       frame_error,
   output logic [4:0] bit_count,
   output logic [3:0] digit,
   output logic       digit_valid
);

   if (FRAME_BITS != 14 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
       (SEG_ACTIVE_LOW != 0 && SEG_ACTIVE_LOW != 1)) begin : g_bad_param
      $error("hc595_frame_receiver: unsupported parameter combination");
   end

   function automatic logic [4:0] sat31(input logic [4:0] c);
      return (c == 5'd31) ? c : c + 5'd1;
   endfunction

   logic [SYNC_STAGES-1:0] ds_sr, shcp_sr, stcp_sr, oe_sr;
   logic                   shcp_prev, stcp_prev;
   logic                   ds_sync, shcp_sync, stcp_sync, oe_sync;
   logic                   shcp_rise, stcp_rise;
   logic [FRAME_BITS-1:0]  shift_reg, latch_reg;
   logic                   vld_p0, err_p0;

   assign ds_sync   = ds_sr[SYNC_STAGES-1];
   assign shcp_sync = shcp_sr[SYNC_STAGES-1];
   assign stcp_sync = stcp_sr[SYNC_STAGES-1];
   assign oe_sync   = oe_sr[SYNC_STAGES-1];
   assign shcp_rise = shcp_sync & ~shcp_prev;
   assign stcp_rise = stcp_sync & ~stcp_prev;

   // Input synchronizers: equal depth on every pin keeps ds aligned with its shcp edge
   always_ff @(posedge system_clock or posedge system_reset) begin
      if (system_reset) begin
         ds_sr     <= '0;
         shcp_sr   <= '0;
         stcp_sr   <= '0;
         oe_sr     <= '0;
         shcp_prev <= 1'b0;
         stcp_prev <= 1'b0;
      end else begin
         ds_sr     <= {ds_sr[SYNC_STAGES-2:0], ds};
         shcp_sr   <= {shcp_sr[SYNC_STAGES-2:0], shcp};
         stcp_sr   <= {stcp_sr[SYNC_STAGES-2:0], stcp};
         oe_sr     <= {oe_sr[SYNC_STAGES-2:0], oe};
         shcp_prev <= shcp_sync;
         stcp_prev <= stcp_sync;
      end
   end

   // Shift/latch stage: a coincident latch sees the pre-shift register and count
   always_ff @(posedge system_clock or posedge system_reset) begin
      if (system_reset) begin
         shift_reg <= '0;
         latch_reg <= '0;
         bit_count <= '0;
         vld_p0    <= 1'b0;
         err_p0    <= 1'b0;
      end else begin
         vld_p0 <= stcp_rise;
         err_p0 <= stcp_rise && (bit_count != 5'(FRAME_BITS));
         if (stcp_rise)
            latch_reg <= shift_reg;
         if (shcp_rise)
            shift_reg <= {shift_reg[FRAME_BITS-2:0], ds_sync};
         if (stcp_rise)
            bit_count <= shcp_rise ? 5'd1 : 5'd0;
         else if (shcp_rise)
            bit_count <= sat31(bit_count);
      end
   end

   // Output stage: frame pulses and blanking-gated pin image
   always_ff @(posedge system_clock or posedge system_reset) begin
      if (system_reset) begin
         seg         <= '0;
         selection   <= '0;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         frame_valid <= vld_p0;
         frame_error <= err_p0;
         seg         <= oe_sync ? 8'h00 : latch_reg[FRAME_BITS-1 -: 8];
         selection   <= oe_sync ? 6'h00 : latch_reg[5:0];
      end
   end

`ifdef SEG_DECODE_EN
   function automatic logic [4:0] seg_decode(input logic [6:0] g);
      case (g)
         7'h3F: return {1'b1, 4'h0};
         7'h06: return {1'b1, 4'h1};
         7'h5B: return {1'b1, 4'h2};
         7'h4F: return {1'b1, 4'h3};
         7'h66: return {1'b1, 4'h4};
         7'h6D: return {1'b1, 4'h5};
         7'h7D: return {1'b1, 4'h6};
         7'h07: return {1'b1, 4'h7};
         7'h7F: return {1'b1, 4'h8};
         7'h6F: return {1'b1, 4'h9};
         7'h77: return {1'b1, 4'hA};
         7'h7C: return {1'b1, 4'hB};
         7'h39: return {1'b1, 4'hC};
         7'h5E: return {1'b1, 4'hD};
         7'h79: return {1'b1, 4'hE};
         7'h71: return {1'b1, 4'hF};
         default: return 5'h00;
      endcase
   endfunction

   logic [7:0] seg_dec;
   logic [4:0] dec_p0;

   assign seg_dec = (SEG_ACTIVE_LOW != 0) ? ~latch_reg[FRAME_BITS-1 -: 8]
                                          :  latch_reg[FRAME_BITS-1 -: 8];
   assign dec_p0  = seg_decode(seg_dec[6:0]);

   // Decode lands alongside frame_valid; an unknown glyph keeps the last digit
   always_ff @(posedge system_clock or posedge system_reset) begin
      if (system_reset) begin
         digit       <= 4'h0;
         digit_valid <= 1'b0;
      end else if (vld_p0) begin
         digit_valid <= dec_p0[4];
         if (dec_p0[4])
            digit <= dec_p0[3:0];
      end
   end
`else
   assign digit       = 4'h0;
   assign digit_valid = 1'b0;
`endif

endmodule

// File: tb/tb_hc595_frame_receiver.sv
// Directed bench for hc595_frame_receiver: table of full frames plus hand sequences for corner cases.
module tb_hc595_frame_receiver;

   logic       clk = 1'b0;
   logic       rst;
   logic       ds, shcp, stcp, oe;
   logic [7:0] seg;
   logic [5:0] selection;
   logic       frame_valid, frame_error;
   logic [4:0] bit_count;
   logic [3:0] digit;
   logic       digit_valid;

   int total = 0;
   int bad   = 0;
   int fv_count = 0;

   hc595_frame_receiver dut (
      .system_clock(clk),
      .system_reset(rst),
      .ds(ds),
      .shcp(shcp),
      .stcp(stcp),
      .oe(oe),
      .seg(seg),
      .selection(selection),
      .frame_valid(frame_valid),
      .frame_error(frame_error),
      .bit_count(bit_count),
      .digit(digit),
      .digit_valid(digit_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (frame_valid) fv_count <= fv_count + 1;

   typedef struct {
      logic [13:0] frame;
      logic [7:0]  seg;
      logic [5:0]  sel;
      logic [3:0]  digit;
      logic        dv;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic shift_bit(input logic b);
      @(negedge clk); ds = b;
      @(negedge clk); shcp = 1'b1;
      repeat (4) @(negedge clk);
      shcp = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic shift_bits(input logic [31:0] val, input int n);
      for (int i = n - 1; i >= 0; i--) shift_bit(val[i]);
   endtask

   // Raise stcp (optionally with shcp) and watch up to 10 cycles for the frame pulse
   task automatic do_latch(input logic with_shift, output int lat, output int pulses, output logic err);
      lat = 0; pulses = 0; err = 1'b0;
      @(negedge clk);
      stcp = 1'b1;
      if (with_shift) shcp = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (frame_valid) begin
            pulses++;
            if (lat == 0) lat = k;
            err = frame_error;
         end
      end
      @(negedge clk);
      stcp = 1'b0;
      shcp = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic chk_digit(input string name, input logic [3:0] d, input logic dv);
`ifdef SEG_DECODE_EN
      chk({name, "_digit"}, digit, d);
      chk({name, "_dvalid"}, digit_valid, dv);
`else
      chk({name, "_digit"}, digit, 4'h0);
      chk({name, "_dvalid"}, digit_valid, 1'b0);
      if (d === 4'hx || dv === 1'bx) $display("note: undefined expectation");
`endif
   endtask

   initial begin
      int   lat, pulses, fv_before;
      logic err;

      vecs[0] = '{14'b00111111_111110, 8'h3F, 6'h3E, 4'h0, 1'b1};
      vecs[1] = '{{8'h6D, 6'h01},      8'h6D, 6'h01, 4'h5, 1'b1};
      vecs[2] = '{{8'hFF, 6'h3F},      8'hFF, 6'h3F, 4'h8, 1'b1};
      vecs[3] = '{{8'h00, 6'h00},      8'h00, 6'h00, 4'h8, 1'b0};
      vecs[4] = '{{8'h71, 6'h2A},      8'h71, 6'h2A, 4'hF, 1'b1};
      vecs[5] = '{{8'hA5, 6'h15},      8'hA5, 6'h15, 4'hF, 1'b0};

      rst = 1'b1; ds = 1'b0; shcp = 1'b0; stcp = 1'b0; oe = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_seg", seg, 8'h00);
      chk("rst_sel", selection, 6'h00);
      chk("rst_fv", frame_valid, 1'b0);
      chk("rst_bitcnt", bit_count, 5'd0);
      chk_digit("rst", 4'h0, 1'b0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("idle_fv_count", fv_count, 0);
      chk("idle_seg", seg, 8'h00);
      chk("idle_sel", selection, 6'h00);

      for (int i = 0; i < 6; i++) begin
         shift_bits(32'(vecs[i].frame), 14);
         chk($sformatf("v%0d_bitcnt_pre", i), bit_count, 5'd14);
         do_latch(1'b0, lat, pulses, err);
         chk($sformatf("v%0d_latency", i), lat, 4);
         chk($sformatf("v%0d_pulses", i), pulses, 1);
         chk($sformatf("v%0d_err", i), err, 1'b0);
         chk($sformatf("v%0d_seg", i), seg, vecs[i].seg);
         chk($sformatf("v%0d_sel", i), selection, vecs[i].sel);
         chk($sformatf("v%0d_bitcnt", i), bit_count, 5'd0);
         chk_digit($sformatf("v%0d", i), vecs[i].digit, vecs[i].dv);
      end

      // Short frame: 10 new bits on top of the retained 6D/01 shift contents
      shift_bits({8'h6D, 6'h01}, 14);
      do_latch(1'b0, lat, pulses, err);
      shift_bits(32'h2B5, 10);
      chk("short_bitcnt_pre", bit_count, 5'd10);
      do_latch(1'b0, lat, pulses, err);
      chk("short_pulses", pulses, 1);
      chk("short_err", err, 1'b1);
      chk("short_seg", seg, 8'h1A);
      chk("short_sel", selection, 6'h35);
      chk("short_bitcnt", bit_count, 5'd0);

      // Output enable blanks and restores without a frame pulse
      fv_before = fv_count;
      @(negedge clk); oe = 1'b1;
      repeat (6) @(negedge clk);
      chk("oe_hi_seg", seg, 8'h00);
      chk("oe_hi_sel", selection, 6'h00);
      oe = 1'b0;
      repeat (6) @(negedge clk);
      chk("oe_lo_seg", seg, 8'h1A);
      chk("oe_lo_sel", selection, 6'h35);
      chk("oe_no_pulse", fv_count, fv_before);

      // Coincident shcp/stcp rise after a full frame
      shift_bits(14'b00111111_111110, 14);
      @(negedge clk); ds = 1'b1;
      do_latch(1'b1, lat, pulses, err);
      chk("sim_pulses", pulses, 1);
      chk("sim_err", err, 1'b0);
      chk("sim_seg", seg, 8'h3F);
      chk("sim_sel", selection, 6'h3E);
      chk("sim_bitcnt", bit_count, 5'd1);

      // Over-length (15 shifts since the coincident edge left one bit counted)
      shift_bits({8'h6D, 6'h01}, 14);
      chk("over_bitcnt_pre", bit_count, 5'd15);
      do_latch(1'b0, lat, pulses, err);
      chk("over_err", err, 1'b1);
      chk("over_seg", seg, 8'h6D);
      chk("over_sel", selection, 6'h01);

      // Saturation: 33 shifts clamp at 31, last 14 bits kept
      shift_bits(32'h7FFFF, 19);
      shift_bits({8'h66, 6'h0C}, 14);
      chk("sat_bitcnt", bit_count, 5'd31);
      do_latch(1'b0, lat, pulses, err);
      chk("sat_err", err, 1'b1);
      chk("sat_seg", seg, 8'h66);
      chk("sat_sel", selection, 6'h0C);
      chk_digit("sat", 4'h4, 1'b1);

      // Reset mid-frame discards the partial frame and does not pulse
      shift_bits(32'h55, 7);
      chk("mid_bitcnt", bit_count, 5'd7);
      fv_before = fv_count;
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("mid_rst_bitcnt", bit_count, 5'd0);
      chk("mid_rst_seg", seg, 8'h00);
      chk("mid_rst_no_pulse", fv_count, fv_before);
      shift_bits({8'h6D, 6'h01}, 14);
      do_latch(1'b0, lat, pulses, err);
      chk("post_rst_latency", lat, 4);
      chk("post_rst_err", err, 1'b0);
      chk("post_rst_seg", seg, 8'h6D);
      chk("post_rst_sel", selection, 6'h01);
      chk_digit("post_rst", 4'h5, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
